// File: rtl/video_pixout.sv
// Video pixel output stage: registers colour/sync/blank on pixel strobes, normalises
// sync polarity and locks the active resolution. Optional dimming: VIDEO_PIXOUT_SCANLINE_EN.
module video_pixout (
    input  logic       clk,
    input  logic       res_n,
    input  logic       pix_stb,
    input  logic [7:0] vred,
    input  logic [7:0] vgrn,
    input  logic [7:0] vblu,
    input  logic       hsync,
    input  logic       vsync,
    input  logic       hblank,
    input  logic       vblank,
    input  logic       scan_en,
    output logic       ce_pix,
    output logic       de,
    output logic [7:0] r,
    output logic [7:0] g,
    output logic [7:0] b,
    output logic       hs,
    output logic       vs,
    output logic       hb,
    output logic       vb,
    output logic       hs_pol,
    output logic       vs_pol,
    output logic [9:0] width,
    output logic [9:0] height,
    output logic       res_valid,
    output logic       res_change
);

    typedef enum logic [1:0] {IDLE, CHECK, LOCKED} lock_state_t;

    lock_state_t state;
    logic        act;
    logic        de_rise;
    logic        de_fall;
    logic        frame_end;
    logic        hs_pol_nxt;
    logic        vs_pol_nxt;
    logic        parity;
    logic        match_cnt;
    logic        meas_eq;
    logic [9:0]  pix_cnt;
    logic [9:0]  line_cnt;
    logic [9:0]  line_w;
    logic [9:0]  line_w_nxt;
    logic [9:0]  prev_w;
    logic [9:0]  prev_h;
    logic [7:0]  red_px;
    logic [7:0]  grn_px;
    logic [7:0]  blu_px;

    // Edges are judged against the previously sampled de/vb, which the output registers hold.
    assign act        = ~hblank & ~vblank;
    assign de_rise    = pix_stb & act & ~de;
    assign de_fall    = pix_stb & ~act & de;
    assign frame_end  = pix_stb & vblank & ~vb;
    assign hs_pol_nxt = de_rise ? ~hsync : hs_pol;
    assign vs_pol_nxt = (de_rise && line_cnt == 10'd0) ? ~vsync : vs_pol;

    // A line ending on the same sample as the frame must contribute its own width.
    assign line_w_nxt = de_fall ? pix_cnt : line_w;
    assign meas_eq    = (line_w_nxt == prev_w) && (line_cnt == prev_h);

`ifdef VIDEO_PIXOUT_SCANLINE_EN
    logic dim;
    assign dim    = scan_en & parity;
    assign red_px = dim ? {1'b0, vred[7:1]} : vred;
    assign grn_px = dim ? {1'b0, vgrn[7:1]} : vgrn;
    assign blu_px = dim ? {1'b0, vblu[7:1]} : vblu;
`else
    logic unused;
    assign unused = scan_en ^ parity;
    assign red_px = vred;
    assign grn_px = vgrn;
    assign blu_px = vblu;
`endif

    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            ce_pix   <= 1'b0;
            de       <= 1'b0;
            r        <= 8'd0;
            g        <= 8'd0;
            b        <= 8'd0;
            hs       <= 1'b0;
            vs       <= 1'b0;
            hb       <= 1'b0;
            vb       <= 1'b0;
            hs_pol   <= 1'b1;
            vs_pol   <= 1'b1;
            pix_cnt  <= 10'd0;
            line_cnt <= 10'd0;
            line_w   <= 10'd0;
            parity   <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments throughout so every register sees pre-edge values.
            ce_pix <= pix_stb;
            if (pix_stb) begin
                de     <= act;
                hb     <= hblank;
                vb     <= vblank;
                r      <= act ? red_px : 8'd0;
                g      <= act ? grn_px : 8'd0;
                b      <= act ? blu_px : 8'd0;
                hs     <= hsync ~^ hs_pol_nxt;
                vs     <= vsync ~^ vs_pol_nxt;
                hs_pol <= hs_pol_nxt;
                vs_pol <= vs_pol_nxt;

                if (act) begin
                    if (pix_cnt != 10'h3FF) pix_cnt <= pix_cnt + 10'd1;
                end else if (de_fall) begin
                    pix_cnt <= 10'd0;
                end

                if (de_fall) begin
                    line_w <= pix_cnt;
                    parity <= ~parity;
                end

                if (de_rise && line_cnt != 10'h3FF) line_cnt <= line_cnt + 10'd1;

                if (frame_end) begin
                    line_cnt <= 10'd0;
                    parity   <= 1'b0;
                end
            end
        end
    end

    // Lock tracker: three consecutive equal measurements lock; any difference unlocks.
    always_ff @(posedge clk or negedge res_n) begin
        if (!res_n) begin
            state      <= IDLE;
            prev_w     <= 10'd0;
            prev_h     <= 10'd0;
            match_cnt  <= 1'b0;
            width      <= 10'd0;
            height     <= 10'd0;
            res_valid  <= 1'b0;
            res_change <= 1'b0;
        end else begin
            res_change <= 1'b0;
            if (frame_end) begin
                if (line_cnt == 10'd0) begin
                    if (state == LOCKED) res_change <= 1'b1;
                    state     <= IDLE;
                    res_valid <= 1'b0;
                    match_cnt <= 1'b0;
                end else begin
                    case (state)
                        IDLE: begin
                            prev_w    <= line_w_nxt;
                            prev_h    <= line_cnt;
                            match_cnt <= 1'b0;
                            state     <= CHECK;
                        end
                        CHECK: begin
                            if (meas_eq) begin
                                if (match_cnt) begin
                                    state     <= LOCKED;
                                    width     <= line_w_nxt;
                                    height    <= line_cnt;
                                    res_valid <= 1'b1;
                                    match_cnt <= 1'b0;
                                end else begin
                                    match_cnt <= 1'b1;
                                end
                            end else begin
                                prev_w    <= line_w_nxt;
                                prev_h    <= line_cnt;
                                match_cnt <= 1'b0;
                            end
                        end
                        LOCKED: begin
                            if (!meas_eq) begin
                                res_change <= 1'b1;
                                res_valid  <= 1'b0;
                                prev_w     <= line_w_nxt;
                                prev_h     <= line_cnt;
                                match_cnt  <= 1'b0;
                                state      <= CHECK;
                            end
                        end
                        default: state <= IDLE;
                    endcase
                end
            end
        end
    end

endmodule

// File: tb/tb_video_pixout.sv
// Self-checking bench for video_pixout: randomized frames checked against a frame-level
// model (line widths/counts, run-of-equal-measurements lock rule, polarity of the generator).
module tb_video_pixout;

    logic       clk = 1'b0;
    logic       res_n = 1'b0;
    logic       pix_stb = 1'b0;
    logic [7:0] vred = 8'd0, vgrn = 8'd0, vblu = 8'd0;
    logic       hsync = 1'b0, vsync = 1'b0, hblank = 1'b1, vblank = 1'b1, scan_en = 1'b0;
    logic       ce_pix, de, hs, vs, hb, vb, hs_pol, vs_pol, res_valid, res_change;
    logic [7:0] r, g, b;
    logic [9:0] width, height;

    video_pixout dut (
        .clk(clk), .res_n(res_n), .pix_stb(pix_stb),
        .vred(vred), .vgrn(vgrn), .vblu(vblu),
        .hsync(hsync), .vsync(vsync), .hblank(hblank), .vblank(vblank), .scan_en(scan_en),
        .ce_pix(ce_pix), .de(de), .r(r), .g(g), .b(b),
        .hs(hs), .vs(vs), .hb(hb), .vb(vb), .hs_pol(hs_pol), .vs_pol(vs_pol),
        .width(width), .height(height), .res_valid(res_valid), .res_change(res_change)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // Generator settings and frame-level model state
    bit         gen_hpol = 1'b1;
    bit         gen_vpol = 1'b1;
    int         gap = 0;
    int         fixed_col = -1;
    bit         h_known, v_known;
    int         run;
    int         last_w, last_h;
    bit         lk;
    logic [9:0] lk_w, lk_h;

    task automatic do_reset();
        @(negedge clk);
        res_n   = 1'b0;
        pix_stb = 1'b0;
        hsync   = ~gen_hpol;
        vsync   = ~gen_vpol;
        repeat (2) @(negedge clk);
        res_n   = 1'b1;
        h_known = 1'b0;
        v_known = 1'b0;
        run     = 0;
        last_w  = 0;
        last_h  = 0;
        lk      = 1'b0;
        lk_w    = 10'd0;
        lk_h    = 10'd0;
    endtask

    // One strobed pixel; called at a falling edge, returns at a falling edge.
    task automatic pix(input bit h_b, input bit v_b, input bit hs_a, input bit vs_a, input bit par);
        logic [7:0]  cr, cg, cb, er, eg, eb;
        logic [31:0] got, exp;
        bit          act, dim;
        cr = (fixed_col >= 0) ? 8'(fixed_col) : 8'($urandom);
        cg = (fixed_col >= 0) ? 8'(fixed_col) : 8'($urandom);
        cb = (fixed_col >= 0) ? 8'(fixed_col) : 8'($urandom);
        vred = cr; vgrn = cg; vblu = cb;
        hblank = h_b; vblank = v_b;
        hsync = hs_a ? gen_hpol : ~gen_hpol;
        vsync = vs_a ? gen_vpol : ~gen_vpol;
        pix_stb = 1'b1;
        act = !h_b && !v_b;
        if (act) begin
            h_known = 1'b1;
            v_known = 1'b1;
        end
`ifdef VIDEO_PIXOUT_SCANLINE_EN
        dim = scan_en && par;
`else
        dim = 1'b0;
`endif
        er = !act ? 8'd0 : (dim ? cr / 2 : cr);
        eg = !act ? 8'd0 : (dim ? cg / 2 : cg);
        eb = !act ? 8'd0 : (dim ? cb / 2 : cb);
        @(negedge clk);
        pix_stb = 1'b0;
        exp = {1'b1, act, h_b, v_b, er, eg, eb,
               h_known ? hs_a : hsync, v_known ? vs_a : vsync,
               h_known ? gen_hpol : 1'b1, v_known ? gen_vpol : 1'b1};
        got = {ce_pix, de, hb, vb, r, g, b, hs, vs, hs_pol, vs_pol};
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL pixel: got=%h expected=%h", got, exp);
        end
        repeat (gap) begin
            @(negedge clk);
            total++;
            if (ce_pix !== 1'b0) begin
                bad++;
                $display("FAIL ce_gap: got=%b expected=0", ce_pix);
            end
        end
    endtask

    task automatic frame_end_check(input int mw, input int mh);
        bit was, chg;
        was = lk;
        if (mh == 0) run = 0;
        else if (run > 0 && mw == last_w && mh == last_h) run++;
        else run = 1;
        last_w = mw;
        last_h = mh;
        lk = (run >= 3);
        if (run == 3) begin
            lk_w = 10'(mw);
            lk_h = 10'(mh);
        end
        chg = was && !lk;
        total++;
        if ({res_valid, width, height, res_change} !== {lk, lk_w, lk_h, chg}) begin
            bad++;
            $display("FAIL lock: got valid=%b w=%0d h=%0d chg=%b expected valid=%b w=%0d h=%0d chg=%b",
                     res_valid, width, height, res_change, lk, lk_w, lk_h, chg);
        end
    endtask

    // Lines 0..nl-2 are short random widths; the last line carries the width to measure.
    task automatic run_frame(input int nl, input int lw, input bit coincide);
        int w, saved;
        if (nl == 0) repeat (2) pix(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        for (int k = 0; k < nl; k++) begin
            w = (k == nl - 1) ? lw : int'($urandom_range(1, 3));
            for (int i = 0; i < w; i++) pix(1'b0, 1'b0, 1'b0, 1'b0, bit'(k % 2));
            if (!(coincide && k == nl - 1))
                repeat ($urandom_range(1, 2)) pix(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        saved = gap;
        gap = 0;
        pix(!coincide, 1'b1, 1'b0, 1'b1, 1'b0);
        frame_end_check((lw > 1023) ? 1023 : lw, (nl > 1023) ? 1023 : nl);
        pix(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
        gap = saved;
        total++;
        if (res_change !== 1'b0) begin
            bad++;
            $display("FAIL change_pulse_len: got=%b expected=0", res_change);
        end
    endtask

    task automatic test_reset();
        logic [44:0] got;
        @(negedge clk);
        res_n = 1'b0;
        for (int i = 0; i < 4; i++) begin
            pix_stb = 1'b1;
            vred = 8'($urandom); vgrn = 8'($urandom); vblu = 8'($urandom);
            hsync = 1'($urandom); vsync = 1'($urandom);
            hblank = 1'b0; vblank = 1'b0;
            @(negedge clk);
            got = {ce_pix, de, r, g, b, hs, vs, hb, vb, hs_pol, vs_pol, width, height, res_valid, res_change};
            total++;
            if (got !== {10'd0, 24'd0, 2'b11, 20'd0, 2'b00} >> 0 && got !== 45'h0_0000_0000_0) begin
            end
            if (got !== {2'b00, 24'd0, 4'b0000, 2'b11, 20'd0, 2'b00}) begin
                bad++;
                $display("FAIL reset_outputs: got=%h expected=%h", got,
                         {2'b00, 24'd0, 4'b0000, 2'b11, 20'd0, 2'b00});
            end
        end
        pix_stb = 1'b0;
        do_reset();
    endtask

    task automatic test_pixel_path();
        gen_hpol = 1'b1; gen_vpol = 1'b1;
        do_reset();
        gap = 1;
        fixed_col = 8'h12;
        run_frame(3, 4, 1'b0);
        gap = 0;
        fixed_col = -1;
    endtask

    task automatic test_polarity();
        gen_hpol = 1'b0; gen_vpol = 1'b0;
        do_reset();
        run_frame(4, 5, 1'b0);
        total++;
        if ({hs_pol, vs_pol} !== 2'b00) begin
            bad++;
            $display("FAIL pol_low: got=%b%b expected=00", hs_pol, vs_pol);
        end
        gen_hpol = 1'b1; gen_vpol = 1'b0;
        do_reset();
        run_frame(3, 6, 1'b0);
        total++;
        if ({hs_pol, vs_pol} !== 2'b10) begin
            bad++;
            $display("FAIL pol_mixed: got=%b%b expected=10", hs_pol, vs_pol);
        end
    endtask

    task automatic test_lock_and_change();
        gen_hpol = 1'($urandom); gen_vpol = 1'($urandom);
        do_reset();
        scan_en = 1'($urandom);
        repeat (3) run_frame(288, 360, 1'b0);
        total++;
        if ({res_valid, width, height} !== {1'b1, 10'd360, 10'd288}) begin
            bad++;
            $display("FAIL lock_360x288: got valid=%b %0dx%0d expected valid=1 360x288", res_valid, width, height);
        end
        run_frame(240, 320, 1'b0);
        total++;
        if ({res_valid, width} !== {1'b0, 10'd360}) begin
            bad++;
            $display("FAIL unlock_hold: got valid=%b w=%0d expected valid=0 w=360", res_valid, width);
        end
        repeat (2) run_frame(240, 320, 1'b0);
        total++;
        if ({res_valid, width, height} !== {1'b1, 10'd320, 10'd240}) begin
            bad++;
            $display("FAIL relock_320x240: got valid=%b %0dx%0d expected valid=1 320x240", res_valid, width, height);
        end
        scan_en = 1'b0;
    endtask

    task automatic test_coincide();
        do_reset();
        repeat (3) run_frame(5, 200, 1'b1);
        total++;
        if ({res_valid, width, height} !== {1'b1, 10'd200, 10'd5}) begin
            bad++;
            $display("FAIL coincide: got valid=%b %0dx%0d expected valid=1 200x5", res_valid, width, height);
        end
    endtask

    task automatic test_saturation();
        do_reset();
        repeat (3) run_frame(4, 1100, 1'b0);
        total++;
        if ({res_valid, width} !== {1'b1, 10'd1023}) begin
            bad++;
            $display("FAIL width_sat: got valid=%b w=%0d expected valid=1 w=1023", res_valid, width);
        end
        run_frame(0, 0, 1'b0);
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL empty_frame: got valid=%b expected=0", res_valid);
        end
        repeat (3) run_frame(1030, 2, 1'b0);
        total++;
        if ({res_valid, width, height} !== {1'b1, 10'd2, 10'd1023}) begin
            bad++;
            $display("FAIL height_sat: got valid=%b %0dx%0d expected valid=1 2x1023", res_valid, width, height);
        end
    endtask

    task automatic test_reset_midframe();
        do_reset();
        repeat (2) run_frame(10, 100, 1'b0);
        for (int k = 0; k < 5; k++) begin
            repeat (7) pix(1'b0, 1'b0, 1'b0, 1'b0, bit'(k % 2));
            pix(1'b1, 1'b0, 1'b1, 1'b0, 1'b0);
        end
        repeat (3) pix(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
        do_reset();
        run_frame(10, 100, 1'b0);
        total++;
        if (res_valid !== 1'b0) begin
            bad++;
            $display("FAIL midreset_idle: got valid=%b expected=0", res_valid);
        end
        repeat (2) run_frame(10, 100, 1'b0);
        total++;
        if ({res_valid, width, height} !== {1'b1, 10'd100, 10'd10}) begin
            bad++;
            $display("FAIL midreset_relock: got valid=%b %0dx%0d expected valid=1 100x10", res_valid, width, height);
        end
    endtask

    task automatic test_scanline();
        gen_hpol = 1'b1; gen_vpol = 1'b1;
        do_reset();
        scan_en = 1'b1;
        fixed_col = 8'hFF;
        run_frame(2, 3, 1'b0);
        run_frame(3, 2, 1'b1);
        scan_en = 1'b0;
        fixed_col = -1;
    endtask

    initial begin
        test_reset();
        test_pixel_path();
        test_polarity();
        test_lock_and_change();
        test_coincide();
        test_saturation();
        test_reset_midframe();
        test_scanline();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
